// File: rtl/risc_spm_pkg.sv
// Shared constants and types for the RISC-SPM control path.
// Opcodes, state encoding, bus selects and instruction field helpers.
package risc_spm_pkg;

    localparam int WORD_SIZE = 8;
    localparam int OP_SIZE   = 4;
    localparam int SEL1_SIZE = 3;
    localparam int SEL2_SIZE = 2;

    localparam logic [OP_SIZE-1:0] OP_NOP = 4'd0;
    localparam logic [OP_SIZE-1:0] OP_ADD = 4'd1;
    localparam logic [OP_SIZE-1:0] OP_SUB = 4'd2;
    localparam logic [OP_SIZE-1:0] OP_AND = 4'd3;
    localparam logic [OP_SIZE-1:0] OP_NOT = 4'd4;
    localparam logic [OP_SIZE-1:0] OP_RD  = 4'd5;
    localparam logic [OP_SIZE-1:0] OP_WR  = 4'd6;
    localparam logic [OP_SIZE-1:0] OP_BR  = 4'd7;
    localparam logic [OP_SIZE-1:0] OP_BRZ = 4'd8;

    localparam logic [SEL1_SIZE-1:0] SEL1_PC = 3'd4;

    localparam logic [SEL2_SIZE-1:0] SEL2_ALU  = 2'd0;
    localparam logic [SEL2_SIZE-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [SEL2_SIZE-1:0] SEL2_MEM  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    typedef struct packed {
        logic [OP_SIZE-1:0]   alu_sel;
        logic [SEL1_SIZE-1:0] sel_bus_1;
        logic [SEL2_SIZE-1:0] sel_bus_2;
        logic [3:0]           load_r;
        logic                 load_pc;
        logic                 inc_pc;
        logic                 load_ir;
        logic                 load_add_r;
        logic                 load_reg_y;
        logic                 load_reg_z;
        logic                 mem_write;
        logic                 halted;
    } ctrl_t;

    function automatic logic [OP_SIZE-1:0] opcode_of(
        input logic [WORD_SIZE-1:0] instr
    );
        return instr[7:4];
    endfunction

    function automatic logic [1:0] src_of(input logic [WORD_SIZE-1:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [1:0] dest_of(input logic [WORD_SIZE-1:0] instr);
        return instr[1:0];
    endfunction

    function automatic logic [3:0] reg_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational decode of state + instruction into strobes and next state.
// Pure function of its inputs; the state register lives in the top.
module risc_ctrl_decode
    import risc_spm_pkg::*;
(
    input  state_t                 state_i,
    input  logic [WORD_SIZE-1:0]   instruction_i,
    input  logic                   zero_i,
    output ctrl_t                  ctrl_o,
    output state_t                 state_d_o
);

    logic [OP_SIZE-1:0] op;
    logic [1:0]         src;
    logic [1:0]         dest;

    assign op   = opcode_of(instruction_i);
    assign src  = src_of(instruction_i);
    assign dest = dest_of(instruction_i);

    // Per-state strobes and transitions; everything defaults to idle/zero
    always_comb begin
        ctrl_o    = '0;
        state_d_o = S_IDLE;
        case (state_i)
            S_IDLE: state_d_o = S_FET1;
            S_FET1: begin
                ctrl_o.sel_bus_1  = SEL1_PC;
                ctrl_o.sel_bus_2  = SEL2_BUS1;
                ctrl_o.load_add_r = 1'b1;
                state_d_o         = S_FET2;
            end
            S_FET2: begin
                ctrl_o.sel_bus_2 = SEL2_MEM;
                ctrl_o.load_ir   = 1'b1;
                ctrl_o.inc_pc    = 1'b1;
                state_d_o        = S_DEC;
            end
            S_DEC: begin
                case (op)
                    OP_NOP: state_d_o = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        ctrl_o.sel_bus_1  = {1'b0, src};
                        ctrl_o.sel_bus_2  = SEL2_BUS1;
                        ctrl_o.load_reg_y = 1'b1;
                        state_d_o         = S_EX1;
                    end
                    OP_NOT: begin
                        ctrl_o.sel_bus_1  = {1'b0, src};
                        ctrl_o.sel_bus_2  = SEL2_ALU;
                        ctrl_o.alu_sel    = OP_NOT;
                        ctrl_o.load_reg_z = 1'b1;
                        ctrl_o.load_r     = reg_onehot(dest);
                        state_d_o         = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        ctrl_o.sel_bus_1  = SEL1_PC;
                        ctrl_o.sel_bus_2  = SEL2_BUS1;
                        ctrl_o.load_add_r = 1'b1;
                        if (op == OP_RD)
                            state_d_o = S_RD1;
                        else if (op == OP_WR)
                            state_d_o = S_WR1;
                        else
                            state_d_o = S_BR1;
                    end
                    OP_BRZ: begin
                        if (zero_i) begin
                            ctrl_o.sel_bus_1  = SEL1_PC;
                            ctrl_o.sel_bus_2  = SEL2_BUS1;
                            ctrl_o.load_add_r = 1'b1;
                            state_d_o         = S_BR1;
                        end else begin
                            // Not taken: step PC over the address byte
                            ctrl_o.inc_pc = 1'b1;
                            state_d_o     = S_FET1;
                        end
                    end
                    default: state_d_o = S_HALT;
                endcase
            end
            S_EX1: begin
                ctrl_o.sel_bus_1  = {1'b0, dest};
                ctrl_o.sel_bus_2  = SEL2_ALU;
                ctrl_o.alu_sel    = op;
                ctrl_o.load_reg_z = 1'b1;
                ctrl_o.load_r     = reg_onehot(dest);
                state_d_o         = S_FET1;
            end
            S_RD1: begin
                ctrl_o.sel_bus_2  = SEL2_MEM;
                ctrl_o.load_add_r = 1'b1;
                ctrl_o.inc_pc     = 1'b1;
                state_d_o         = S_RD2;
            end
            S_RD2: begin
                ctrl_o.sel_bus_2 = SEL2_MEM;
                ctrl_o.load_r    = reg_onehot(dest);
                state_d_o        = S_FET1;
            end
            S_WR1: begin
                ctrl_o.sel_bus_2  = SEL2_MEM;
                ctrl_o.load_add_r = 1'b1;
                ctrl_o.inc_pc     = 1'b1;
                state_d_o         = S_WR2;
            end
            S_WR2: begin
                ctrl_o.sel_bus_1 = {1'b0, src};
                ctrl_o.mem_write = 1'b1;
                state_d_o        = S_FET1;
            end
            S_BR1: begin
                ctrl_o.sel_bus_2  = SEL2_MEM;
                ctrl_o.load_add_r = 1'b1;
                state_d_o         = S_BR2;
            end
            S_BR2: begin
                ctrl_o.sel_bus_2 = SEL2_MEM;
                ctrl_o.load_pc   = 1'b1;
                state_d_o        = S_FET1;
            end
            S_HALT: begin
                ctrl_o.halted = 1'b1;
                state_d_o     = S_HALT;
            end
            default: state_d_o = S_IDLE;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// Multi-cycle control FSM for the RISC-SPM datapath.
// Holds the state register; strobes come from risc_ctrl_decode.
module risc_control_unit
    import risc_spm_pkg::*;
#(
    parameter int WORD_SIZE_P = WORD_SIZE,
    parameter int OP_SIZE_P   = OP_SIZE,
    parameter int SEL1_SIZE_P = SEL1_SIZE,
    parameter int SEL2_SIZE_P = SEL2_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_SIZE_P-1:0] instruction,
    input  logic                   zero,
    output logic [OP_SIZE_P-1:0]   alu_sel,
    output logic [SEL1_SIZE_P-1:0] sel_bus_1,
    output logic [SEL2_SIZE_P-1:0] sel_bus_2,
    output logic [3:0]             load_r,
    output logic                   load_pc,
    output logic                   inc_pc,
    output logic                   load_ir,
    output logic                   load_add_r,
    output logic                   load_reg_y,
    output logic                   load_reg_z,
    output logic                   mem_write,
    output logic                   halted
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    risc_ctrl_decode u_decode (
        .state_i       (state_q),
        .instruction_i (instruction),
        .zero_i        (zero),
        .ctrl_o        (ctrl),
        .state_d_o     (state_d)
    );

    // State register with synchronous active-low reset to S_IDLE
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign alu_sel    = ctrl.alu_sel;
    assign sel_bus_1  = ctrl.sel_bus_1;
    assign sel_bus_2  = ctrl.sel_bus_2;
    assign load_r     = ctrl.load_r;
    assign load_pc    = ctrl.load_pc;
    assign inc_pc     = ctrl.inc_pc;
    assign load_ir    = ctrl.load_ir;
    assign load_add_r = ctrl.load_add_r;
    assign load_reg_y = ctrl.load_reg_y;
    assign load_reg_z = ctrl.load_reg_z;
    assign mem_write  = ctrl.mem_write;
    assign halted     = ctrl.halted;

endmodule

// File: tb/tb_risc_control_unit.sv
// Directed bench for risc_control_unit.
// Walks each instruction class cycle by cycle against hand-built vectors.
module tb_risc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
    logic [3:0] alu_sel;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic [3:0] load_r;
    logic       load_pc, inc_pc, load_ir, load_add_r;
    logic       load_reg_y, load_reg_z, mem_write, halted;

    int checks = 0;
    int passes = 0;

    risc_control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
        .alu_sel     (alu_sel),
        .sel_bus_1   (sel_bus_1),
        .sel_bus_2   (sel_bus_2),
        .load_r      (load_r),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .load_add_r  (load_add_r),
        .load_reg_y  (load_reg_y),
        .load_reg_z  (load_reg_z),
        .mem_write   (mem_write),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // obs = {alu_sel, sel1, sel2, load_r, pc, inc, ir, add_r, y, z, mw, halted}
    logic [20:0] obs;
    assign obs = {alu_sel, sel_bus_1, sel_bus_2, load_r,
                  load_pc, inc_pc, load_ir, load_add_r,
                  load_reg_y, load_reg_z, mem_write, halted};

    function automatic logic [20:0] mk(
        input logic [3:0] a, input logic [2:0] s1, input logic [1:0] s2,
        input logic [3:0] lr, input logic [7:0] st
    );
        return {a, s1, s2, lr, st};
    endfunction

    // strobe byte: {pc, inc, ir, add_r, y, z, mw, halted}
    localparam logic [20:0] E_IDLE = '0;
    localparam logic [20:0] E_FET1 = {4'd0, 3'd4, 2'd1, 4'd0, 8'b0001_0000};
    localparam logic [20:0] E_FET2 = {4'd0, 3'd0, 2'd2, 4'd0, 8'b0110_0000};
    localparam logic [20:0] E_ADDR = {4'd0, 3'd4, 2'd1, 4'd0, 8'b0001_0000};
    localparam logic [20:0] E_MEM1 = {4'd0, 3'd0, 2'd2, 4'd0, 8'b0101_0000};
    localparam logic [20:0] E_BR1  = {4'd0, 3'd0, 2'd2, 4'd0, 8'b0001_0000};
    localparam logic [20:0] E_BR2  = {4'd0, 3'd0, 2'd2, 4'd0, 8'b1000_0000};
    localparam logic [20:0] E_HALT = {4'd0, 3'd0, 2'd0, 4'd0, 8'b0000_0001};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        instruction = 8'h00;
        zero = 1'b0;
        step();
        if (obs !== E_IDLE) $display("FAIL reset_idle got %h want %h", obs, E_IDLE);
        else passes++;
        checks++;
        rst = 1'b1;
        step();
        if (obs !== E_FET1) $display("FAIL reset_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
    endtask

    task automatic test_add();
        instruction = 8'h16;
        if (obs !== E_FET1) $display("FAIL add_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        if (obs !== E_FET2) $display("FAIL add_fet2 got %h want %h", obs, E_FET2);
        else passes++;
        checks++;
        step();
        if (obs !== mk(4'd0, 3'd1, 2'd1, 4'd0, 8'b0000_1000))
            $display("FAIL add_dec got %h", obs);
        else passes++;
        checks++;
        step();
        if (obs !== mk(4'd1, 3'd2, 2'd0, 4'b0100, 8'b0000_0100))
            $display("FAIL add_ex1 got %h", obs);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_sub_and();
        instruction = 8'h21;
        if (obs !== E_FET1) $display("FAIL sub_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== mk(4'd0, 3'd0, 2'd1, 4'd0, 8'b0000_1000))
            $display("FAIL sub_dec got %h", obs);
        else passes++;
        checks++;
        step();
        if (obs !== mk(4'd2, 3'd1, 2'd0, 4'b0010, 8'b0000_0100))
            $display("FAIL sub_ex1 got %h", obs);
        else passes++;
        checks++;
        step();
        instruction = 8'h3B;
        if (obs !== E_FET1) $display("FAIL and_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== mk(4'd0, 3'd2, 2'd1, 4'd0, 8'b0000_1000))
            $display("FAIL and_dec got %h", obs);
        else passes++;
        checks++;
        step();
        if (obs !== mk(4'd3, 3'd3, 2'd0, 4'b1000, 8'b0000_0100))
            $display("FAIL and_ex1 got %h", obs);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_not();
        instruction = 8'h4C;
        if (obs !== E_FET1) $display("FAIL not_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== mk(4'd4, 3'd3, 2'd0, 4'b0001, 8'b0000_0100))
            $display("FAIL not_dec got %h", obs);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_nop();
        instruction = 8'h00;
        if (obs !== E_FET1) $display("FAIL nop_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== E_IDLE) $display("FAIL nop_dec got %h want %h", obs, E_IDLE);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_rd();
        instruction = 8'h57;
        if (obs !== E_FET1) $display("FAIL rd_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== E_ADDR) $display("FAIL rd_dec got %h want %h", obs, E_ADDR);
        else passes++;
        checks++;
        step();
        if (obs !== E_MEM1) $display("FAIL rd_rd1 got %h want %h", obs, E_MEM1);
        else passes++;
        checks++;
        step();
        if (obs !== mk(4'd0, 3'd0, 2'd2, 4'b1000, 8'b0000_0000))
            $display("FAIL rd_rd2 got %h", obs);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_wr();
        instruction = 8'h68;
        if (obs !== E_FET1) $display("FAIL wr_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== E_ADDR) $display("FAIL wr_dec got %h want %h", obs, E_ADDR);
        else passes++;
        checks++;
        step();
        if (obs !== E_MEM1) $display("FAIL wr_wr1 got %h want %h", obs, E_MEM1);
        else passes++;
        checks++;
        step();
        if (obs !== mk(4'd0, 3'd2, 2'd0, 4'd0, 8'b0000_0010))
            $display("FAIL wr_wr2 got %h", obs);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_br();
        instruction = 8'h70;
        if (obs !== E_FET1) $display("FAIL br_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== E_ADDR) $display("FAIL br_dec got %h want %h", obs, E_ADDR);
        else passes++;
        checks++;
        step();
        if (obs !== E_BR1) $display("FAIL br_br1 got %h want %h", obs, E_BR1);
        else passes++;
        checks++;
        step();
        if (obs !== E_BR2) $display("FAIL br_br2 got %h want %h", obs, E_BR2);
        else passes++;
        checks++;
        step();
    endtask

    task automatic test_brz();
        instruction = 8'h80;
        zero = 1'b1;
        if (obs !== E_FET1) $display("FAIL brzt_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== E_ADDR) $display("FAIL brzt_dec got %h want %h", obs, E_ADDR);
        else passes++;
        checks++;
        step();
        if (obs !== E_BR1) $display("FAIL brzt_br1 got %h want %h", obs, E_BR1);
        else passes++;
        checks++;
        step();
        if (obs !== E_BR2) $display("FAIL brzt_br2 got %h want %h", obs, E_BR2);
        else passes++;
        checks++;
        step();
        zero = 1'b0;
        if (obs !== E_FET1) $display("FAIL brzn_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
        step();
        step();
        if (obs !== mk(4'd0, 3'd0, 2'd0, 4'd0, 8'b0100_0000))
            $display("FAIL brzn_dec got %h", obs);
        else passes++;
        checks++;
        step();
        if (obs !== E_FET1) $display("FAIL brzn_back got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
    endtask

    task automatic test_reset_mid();
        instruction = 8'h16;
        step();
        step();
        step();
        if (obs !== mk(4'd1, 3'd2, 2'd0, 4'b0100, 8'b0000_0100))
            $display("FAIL rmid_ex1 got %h", obs);
        else passes++;
        checks++;
        rst = 1'b0;
        step();
        if (obs !== E_IDLE) $display("FAIL rmid_idle1 got %h want %h", obs, E_IDLE);
        else passes++;
        checks++;
        step();
        if (obs !== E_IDLE) $display("FAIL rmid_idle2 got %h want %h", obs, E_IDLE);
        else passes++;
        checks++;
        rst = 1'b1;
        step();
        if (obs !== E_FET1) $display("FAIL rmid_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
    endtask

    task automatic test_halt();
        instruction = 8'hF0;
        step();
        step();
        if (obs !== E_IDLE) $display("FAIL halt_dec got %h want %h", obs, E_IDLE);
        else passes++;
        checks++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs !== E_HALT)
                $display("FAIL halt_hold%0d got %h want %h", i, obs, E_HALT);
            else passes++;
            checks++;
        end
        rst = 1'b0;
        step();
        if (obs !== E_IDLE) $display("FAIL halt_rst got %h want %h", obs, E_IDLE);
        else passes++;
        checks++;
        rst = 1'b1;
        step();
        if (obs !== E_FET1) $display("FAIL halt_fet1 got %h want %h", obs, E_FET1);
        else passes++;
        checks++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and();
        test_not();
        test_nop();
        test_rd();
        test_wr();
        test_br();
        test_brz();
        test_reset_mid();
        test_halt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
